mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/cpuDefine.sv | 49 ++++
 rtl/div_iter.sv | 47 ++++
 rtl/mul_div_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpuDefine.sv
// rtl/cpuDefine.sv - shared datapath types, ALU op encodings and mul/div FSM states
package cpuDefine;

  typedef logic [31:0] DType;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_MUL   = 4'd8,
    ALU_MULH  = 4'd9,
    ALU_MULHU = 4'd10,
    ALU_DIV   = 4'd11,
    ALU_MOD   = 4'd12,
    ALU_DIVU  = 4'd13,
    ALU_MODU  = 4'd14
  } AluCtrl;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } MdState;

  localparam logic [4:0] DIV_CNT_MAX = 5'd31;

  function automatic logic is_mul_op(input AluCtrl op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
  endfunction

  function automatic logic is_div_op(input AluCtrl op);
    return (op == ALU_DIV) || (op == ALU_MOD) || (op == ALU_DIVU) || (op == ALU_MODU);
  endfunction

  function automatic logic is_signed_div(input AluCtrl op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

  function automatic logic is_rem_op(input AluCtrl op);
    return (op == ALU_MOD) || (op == ALU_MODU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - restoring radix-2 divider datapath, one quotient bit per step
module div_iter
  import cpuDefine::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  DType       dividend,
  input  DType       divisor,
  output logic [4:0] count,
  output DType       quot_nxt,
  output DType       rem_nxt
);

  DType        quot;
  DType        rem;
  logic [32:0] rem_sh;
  logic        fits;
  DType        sub;

  // The quotient register doubles as the dividend shifter; its MSB feeds the remainder.
  always_comb begin
    rem_sh   = {rem, quot[31]};
    fits     = rem_sh >= {1'b0, divisor};
    sub      = rem_sh[31:0] - divisor;
    rem_nxt  = fits ? sub : rem_sh[31:0];
    quot_nxt = {quot[30:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quot  <= '0;
      rem   <= '0;
      count <= '0;
    end else if (load) begin
      quot  <= dividend;
      rem   <= '0;
      count <= DIV_CNT_MAX;
    end else if (step) begin
      quot <= quot_nxt;
      rem  <= rem_nxt;
      if (count != 5'd0) count <= count - 5'd1;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - single-issue multiply/divide unit with valid/ready request and response
module mul_div_unit
  import cpuDefine::*;
#(
  parameter int DIV_EARLY_OUT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_valid,
  output logic   req_ready,
  input  AluCtrl req_op,
  input  DType   req_src1,
  input  DType   req_src2,
  input  logic   flush,
  output logic   resp_valid,
  input  logic   resp_ready,
  output DType   resp_data
);

  MdState      state, state_nxt;
  AluCtrl      op_q;
  DType        src1_q, src2_q;
  logic        accept;
  logic        div_sgn_in;
  DType        mag1, mag2;
  logic [4:0]  count;
  DType        quot_nxt, rem_nxt;
  logic        early;
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, prod;
  DType        mul_res, div_res;
  logic        neg_q, neg_r;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_ready && req_valid && !flush;

  assign div_sgn_in = is_signed_div(req_op);
  assign mag1 = (div_sgn_in && req_src1[31]) ? -req_src1 : req_src1;
  assign mag2 = (div_sgn_in && req_src2[31]) ? -req_src2 : req_src2;

  div_iter u_div_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && is_div_op(req_op)),
    .step     (state == DIV),
    .dividend (mag1),
    .divisor  (mag2),
    .count    (count),
    .quot_nxt (quot_nxt),
    .rem_nxt  (rem_nxt)
  );

  assign early = (DIV_EARLY_OUT != 0) && ((src1_q == '0) || (src2_q == '0));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) begin
        if (is_mul_op(req_op))      state_nxt = MUL;
        else if (is_div_op(req_op)) state_nxt = DIV;
        else                        state_nxt = DONE;
      end
      MUL:  state_nxt = DONE;
      DIV:  if (early || count == 5'd0) state_nxt = DONE;
      DONE: if (resp_ready) state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Sign-extending both operands to 64 bits lets one modular multiply serve signed and unsigned ops.
  always_comb begin
    mul_sgn = (op_q == ALU_MULH);
    mul_a   = {{32{mul_sgn & src1_q[31]}}, src1_q};
    mul_b   = {{32{mul_sgn & src2_q[31]}}, src2_q};
    prod    = mul_a * mul_b;
    mul_res = (op_q == ALU_MUL) ? prod[31:0] : prod[63:32];
  end

  always_comb begin
    neg_q = is_signed_div(op_q) && (src1_q[31] ^ src2_q[31]);
    neg_r = is_signed_div(op_q) && src1_q[31];
    if (src2_q == '0)      div_res = is_rem_op(op_q) ? src1_q : '1;
    else if (src1_q == '0) div_res = '0;
    else if (is_rem_op(op_q)) div_res = neg_r ? -rem_nxt : rem_nxt;
    else                   div_res = neg_q ? -quot_nxt : quot_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= ALU_ADD;
      src1_q    <= '0;
      src2_q    <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= req_op;
        src1_q <= req_src1;
        src2_q <= req_src2;
        if (!is_mul_op(req_op) && !is_div_op(req_op)) resp_data <= '0;
      end
      if (state == MUL) resp_data <= mul_res;
      else if (state == DIV && state_nxt == DONE) resp_data <= div_res;
    end
  end

endmodule
